// File: rtl/rr_port_arb5_pkg.sv
// Shared definitions for the five-port packet-locked round-robin arbiter.
// Holds the requester count, id width, FSM encoding and pointer arithmetic.
package rr_port_arb5_pkg;

    localparam int N_REQ             = 5;
    localparam int ID_W              = 3;
    localparam int MAX_BEATS_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_t;

    // Requester index after id, wrapping 4 back to 0.
    function automatic logic [ID_W-1:0] nextPtr(input logic [ID_W-1:0] id);
        return (id >= ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotating-priority picker: first set request at or after ptr.
// Shared by the idle arbitration and the same-cycle hand-off on release.
module rr_pick5
    import rr_port_arb5_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] winner,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    always_comb begin
        logic [3:0]      sum;
        logic [ID_W-1:0] cand;
        winner = '0;
        id     = '0;
        any    = 1'b0;
        sum    = '0;
        cand   = '0;
        // Walk offsets 0..4 from ptr; the first hit wins and later hits are ignored.
        for (int k = 0; k < N_REQ; k++) begin
            sum  = {1'b0, ptr} + 4'(k);
            cand = (sum >= 4'(N_REQ)) ? ID_W'(sum - 4'(N_REQ)) : sum[ID_W-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                id           = cand;
                winner       = '0;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_port_arb5.sv
// Five-requester round-robin arbiter for a shared output port; a grant is
// locked for a whole packet and handed to the next requester without a bubble.
module rr_port_arb5
    import rr_port_arb5_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_id,
    output logic             out_valid,
    output logic             err_overlong
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    arbState_t        state, stateNext;
    logic [ID_W-1:0]  ptr, ptrNext;
    logic [N_REQ-1:0] gntNext;
    logic [ID_W-1:0]  gntIdNext;
    logic             gntVldNext;
    logic [7:0]       beatCnt, beatCntNext;
    logic             errNext;

    logic             fire, ownerLast, atLimit, releaseNow, forced;
    logic [N_REQ-1:0] pickReq, pickWinner;
    logic [ID_W-1:0]  pickPtr, pickId;
    logic             pickAny;

    // gnt is one-hot and only non-zero while busy, so this equals req[gnt_id] qualified by gnt_vld.
    assign out_valid  = |(gnt & req);
    assign fire       = out_valid & out_ready;
    assign ownerLast  = |(gnt & last);
    assign atLimit    = (beatCnt == LAST_BEAT);
    assign releaseNow = (state == BUSY) & fire & (ownerLast | atLimit);
    assign forced     = (state == BUSY) & fire & ~ownerLast & atLimit;

    // On release the outgoing owner is masked and priority starts just after it.
    assign pickReq = (state == BUSY) ? (req & ~gnt) : req;
    assign pickPtr = (state == BUSY) ? nextPtr(gnt_id) : ptr;

    rr_pick5 uPick (
        .req    (pickReq),
        .ptr    (pickPtr),
        .winner (pickWinner),
        .id     (pickId),
        .any    (pickAny)
    );

    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        gntNext     = gnt;
        gntIdNext   = gnt_id;
        gntVldNext  = gnt_vld;
        beatCntNext = beatCnt;
        errNext     = 1'b0;
        case (state)
            IDLE: begin
                if (pickAny) begin
                    stateNext   = BUSY;
                    gntNext     = pickWinner;
                    gntIdNext   = pickId;
                    gntVldNext  = 1'b1;
                    beatCntNext = '0;
                end
            end
            BUSY: begin
                if (releaseNow) begin
                    ptrNext     = pickPtr;
                    errNext     = forced;
                    beatCntNext = '0;
                    if (pickAny) begin
                        gntNext    = pickWinner;
                        gntIdNext  = pickId;
                        gntVldNext = 1'b1;
                    end else begin
                        stateNext  = IDLE;
                        gntNext    = '0;
                        gntIdNext  = '0;
                        gntVldNext = 1'b0;
                    end
                end else if (fire) begin
                    beatCntNext = beatCnt + 8'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            gnt_id       <= '0;
            gnt_vld      <= 1'b0;
            beatCnt      <= '0;
            err_overlong <= 1'b0;
        end else begin
            state        <= stateNext;
            ptr          <= ptrNext;
            gnt          <= gntNext;
            gnt_id       <= gntIdNext;
            gnt_vld      <= gntVldNext;
            beatCnt      <= beatCntNext;
            err_overlong <= errNext;
        end
    end

endmodule

// File: tb/tb_rr_port_arb5.sv
// Scenario bench for rr_port_arb5: expected {gnt, gnt_id, gnt_vld, err_overlong}
// words are queued as stimulus is applied and popped once the edge has passed.
module tb_rr_port_arb5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req, last;
    logic       out_ready;
    logic [4:0] gnt;
    logic       gnt_vld;
    logic [2:0] gnt_id;
    logic       out_valid;
    logic       err_overlong;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [9:0] expQ[$];
    logic [9:0] got, want;

    rr_port_arb5 #(.MAX_BEATS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .last         (last),
        .out_ready    (out_ready),
        .gnt          (gnt),
        .gnt_vld      (gnt_vld),
        .gnt_id       (gnt_id),
        .out_valid    (out_valid),
        .err_overlong (err_overlong)
    );

    always #5 clk = ~clk;

    // Expected observation word for owner id (negative means idle).
    function automatic logic [9:0] expGrant(input int id, input logic err);
        if (id < 0) return {5'b0, 3'b0, 1'b0, err};
        return {5'(1 << id), 3'(id), 1'b1, err};
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 5'b11111;
        last      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got  = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expGrant(-1, 1'b0);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL reset_state got=%h want=%h", got, want);
        end
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_basic();
        resetDut();
        req = 5'b00110;
        expQ.push_back(expGrant(1, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL basic_grant got=%h want=%h", got, want);
        end
        last      = 5'b00010;
        out_ready = 1'b1;
        #1;
        testsRun++;
        if (out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL basic_out_valid got=%b want=1", out_valid);
        end
        expQ.push_back(expGrant(2, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL basic_handoff got=%h want=%h", got, want);
        end
        req  = 5'b00100;
        last = 5'b00100;
        expQ.push_back(expGrant(-1, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL basic_to_idle got=%h want=%h", got, want);
        end
    endtask

    task automatic test_round_robin();
        resetDut();
        req       = 5'b11111;
        last      = 5'b11111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expQ.push_back(expGrant(i % 5, 1'b0));
            advance();
            got = {gnt, gnt_id, gnt_vld, err_overlong};
            want = expQ.pop_front();
            testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL rr_seq[%0d] got=%h want=%h", i, got, want);
            end
        end
        req = 5'b00001;
        expQ.push_back(expGrant(-1, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL rr_drain got=%h want=%h", got, want);
        end
    endtask

    task automatic test_lock();
        resetDut();
        req = 5'b01000;
        expQ.push_back(expGrant(3, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL lock_grant got=%h want=%h", got, want);
        end
        // Beats fire on k=0,2,4,6; owner tail is shown while stalled at k=5 and must be ignored.
        for (int k = 0; k < 7; k++) begin
            out_ready = (k % 2 == 0);
            req       = (k >= 1) ? 5'b01010 : 5'b01000;
            last      = (k >= 5) ? 5'b01010 : 5'b00010;
            expQ.push_back(expGrant((k == 6) ? 1 : 3, 1'b0));
            advance();
            got = {gnt, gnt_id, gnt_vld, err_overlong};
            want = expQ.pop_front();
            testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL lock_hold[%0d] got=%h want=%h", k, got, want);
            end
        end
    endtask

    task automatic test_overlong();
        resetDut();
        req = 5'b00100;
        expQ.push_back(expGrant(2, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL overlong_grant got=%h want=%h", got, want);
        end
        req       = 5'b10101;
        last      = 5'b00000;
        out_ready = 1'b1;
        for (int b = 1; b <= 16; b++) begin
            expQ.push_back((b < 16) ? expGrant(2, 1'b0) : expGrant(4, 1'b1));
            advance();
            got = {gnt, gnt_id, gnt_vld, err_overlong};
            want = expQ.pop_front();
            testsRun++;
            if (got !== want) begin
                testsFailed++;
                $display("[TB] FAIL overlong_beat[%0d] got=%h want=%h", b, got, want);
            end
        end
        out_ready = 1'b0;
        expQ.push_back(expGrant(4, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL overlong_pulse_end got=%h want=%h", got, want);
        end
    endtask

    task automatic test_wrap_and_reset();
        resetDut();
        req = 5'b10000;
        expQ.push_back(expGrant(4, 1'b0));
        advance();
        req       = 5'b10001;
        last      = 5'b10000;
        out_ready = 1'b1;
        expQ.push_back(expGrant(0, 1'b0));
        advance();
        req  = 5'b00011;
        last = 5'b00001;
        expQ.push_back(expGrant(1, 1'b0));
        advance();
        last = 5'b00000;
        expQ.push_back(expGrant(1, 1'b0));
        advance();
        for (int i = 0; i < 4; i++) begin
            want = expQ.pop_front();
            testsRun++;
            if (i == 3) begin
                got = {gnt, gnt_id, gnt_vld, err_overlong};
                if (got !== want) begin
                    testsFailed++;
                    $display("[TB] FAIL wrap_midpacket got=%h want=%h", got, want);
                end
            end else begin
                testsRun--;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        testsRun++;
        if (got !== expGrant(-1, 1'b0) || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset got=%h out_valid=%b want=000 out_valid=0", got, out_valid);
        end
        advance();
        rst_n = 1'b1;
        testsRun++;
        if (err_overlong !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_pulse got=%b want=0", err_overlong);
        end
        req       = 5'b00011;
        out_ready = 1'b0;
        expQ.push_back(expGrant(0, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_ptr got=%h want=%h", got, want);
        end
    endtask

    // Separate wrap check: owner 4 hand-off to requester 0 through the masked pointer wrap.
    task automatic test_wrap();
        resetDut();
        req = 5'b10000;
        expQ.push_back(expGrant(4, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL wrap_grant4 got=%h want=%h", got, want);
        end
        req       = 5'b10001;
        last      = 5'b10000;
        out_ready = 1'b1;
        expQ.push_back(expGrant(0, 1'b0));
        advance();
        got = {gnt, gnt_id, gnt_vld, err_overlong};
        want = expQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL wrap_to0 got=%h want=%h", got, want);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_lock();
        test_overlong();
        test_wrap();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
